// File: rtl/game_controller_pkg.sv
// game_controller_pkg
//   Shared definitions for the memory-game controller: FSM state encodings,
//   state width and default timing parameters.
//   Build option: KEY_DEBOUNCE_EN (see key_edge_detect).
package game_controller_pkg;

    localparam int unsigned STATE_W                 = 3;
    localparam int unsigned TICK_CYCLES_DEFAULT     = 50_000_000; // 1 s at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;    // 10 ms at 50 MHz

    typedef enum logic [STATE_W-1:0] {
        ST_INIT       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_PLAY_FPGA  = 3'd2,
        ST_PLAY_USER  = 3'd3,
        ST_CHECK      = 3'd4,
        ST_NEXT_ROUND = 3'd5,
        ST_RESULT     = 3'd6
    } state_e;

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect
//   Brings the raw active-low ENTER button into the clock domain and turns each
//   press into a single-cycle pulse.
//   Build option KEY_DEBOUNCE_EN:
//     defined   - 2-FF sync, then press accepted after DEBOUNCE_CYCLES consecutive
//                 low samples; one high sample re-arms for the next press.
//     undefined - 2-FF sync plus falling-edge detect (pulse 3 cycles after the fall).
// Ports
//   clk_i    in  clock
//   rst_i    in  synchronous active-high reset
//   key_n_i  in  raw button, active low, asynchronous
//   enter_o  out 1-cycle pulse per accepted press
module key_edge_detect #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic enter_o
);

    logic sync1_q, sync2_q;
    logic enter_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    // Cleared by reset, so a key held through reset must be released first.
    logic             armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            enter_q <= 1'b0;
            if (sync2_q) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else if (armed_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    enter_q <= 1'b1;
                    armed_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
`else
    logic prev_q;
    logic unused_deb;

    assign unused_deb = (DEBOUNCE_CYCLES == 0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            prev_q  <= sync2_q;
            enter_q <= prev_q & ~sync2_q;
        end
    end
`endif

    assign enter_o = enter_q;

endmodule

// File: rtl/game_controller.sv
// game_controller
//   Control FSM for the memory game. Reads datapath status flags, drives the
//   datapath command strobes and generates the game tick. Owns one
//   key_edge_detect for the ENTER button (build option KEY_DEBOUNCE_EN).
// Ports
//   CLOCK_50   in   system clock (rising edge)
//   RESET      in   synchronous active-high reset
//   KEY_ENTER  in   raw ENTER button, active low
//   end_FPGA, end_User, end_time, win, match   in   datapath status
//   R1, R2, E1..E4, SEL                         out  datapath commands
//   state      out  current FSM state (debug LEDs)
// Outputs decode only from state_q, tick_q and enter_q; status inputs only
// steer the next state, so there is no input-to-output combinational path.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               KEY_ENTER,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_q;
    logic              enter_q;
    logic              tick_clr;

    key_edge_detect #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .key_n_i(KEY_ENTER),
        .enter_o(enter_q)
    );

    // Timebase restarts on entry to either play state so the first tick
    // arrives a full period after entry.
    assign tick_clr = (state_d != state_q) &&
                      ((state_d == ST_PLAY_FPGA) || (state_d == ST_PLAY_USER));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_INIT;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tick_clr) begin
                tick_cnt_q <= '0;
                tick_q     <= 1'b0;
            end else if (tick_cnt_q == TICK_W'(TICK_CYCLES - 1)) begin
                tick_cnt_q <= '0;
                tick_q     <= 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                tick_q     <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (state_q)
            ST_INIT: begin
                R1      = 1'b1;
                R2      = 1'b1;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                E1 = 1'b1;
                R2 = enter_q;         // exit cycle is exactly the enter_q cycle
                if (enter_q) state_d = ST_PLAY_FPGA;
            end
            ST_PLAY_FPGA: begin
                // User-entry side is idle while the sequence plays, so R2 is held
                // for the whole state; this covers the exit cycle without
                // decoding end_FPGA into an output.
                R2 = 1'b1;
                E3 = tick_q;
                if (end_FPGA) state_d = ST_PLAY_USER;
            end
            ST_PLAY_USER: begin
                E2 = tick_q;
                E4 = enter_q;
                if (end_User)      state_d = ST_CHECK;
                else if (end_time) state_d = ST_RESULT;
            end
            ST_CHECK: begin
                state_d = (match && !win) ? ST_NEXT_ROUND : ST_RESULT;
            end
            ST_NEXT_ROUND: begin
                R2      = 1'b1;
                state_d = ST_PLAY_FPGA;
            end
            ST_RESULT: begin
                SEL = 1'b1;
                if (enter_q) state_d = ST_INIT;
            end
            default: state_d = ST_INIT;   // encoding 7
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller
//   Directed bench for game_controller with TICK_CYCLES=4, DEBOUNCE_CYCLES=3.
//   Output vector order: {R1,R2,E1,E2,E3,E4,SEL}.
module tb_game_controller;

    localparam int TICK = 4;
    localparam int DEB  = 3;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT       = 5;  // fall -> enter_q: 2 sync + 3 low samples
    localparam int GLITCH_E4 = 0;
`else
    localparam int LAT       = 3;
    localparam int GLITCH_E4 = 1;
`endif

    logic       CLOCK_50  = 1'b0;
    logic       RESET     = 1'b1;
    logic       KEY_ENTER = 1'b1;
    logic       end_FPGA  = 1'b0;
    logic       end_User  = 1'b0;
    logic       end_time  = 1'b0;
    logic       win       = 1'b0;
    logic       match     = 1'b0;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state;
    logic [6:0] outs;

    int errors = 0;
    int checks = 0;
    int e2_cnt, e4_cnt;

    assign outs = {R1, R2, E1, E2, E3, E4, SEL};

    always #5 CLOCK_50 = ~CLOCK_50;

    game_controller #(
        .TICK_CYCLES    (TICK),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_ENTER(KEY_ENTER),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state    (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Returns in the cycle where enter_q is high.
    task automatic press();
        KEY_ENTER = 1'b0;
        step(LAT);
        KEY_ENTER = 1'b1;
    endtask

    initial begin
        // Reset
        step(2);
        chk("rst_state", state, 0);
        chk("rst_outs", outs, 7'b1100000);
        RESET = 1'b0;
        step(1);
        chk("setup_state", state, 1);
        chk("setup_outs", outs, 7'b0010000);
        step(3);

        // SETUP -> PLAY_FPGA with R2 only in the exit cycle
        KEY_ENTER = 1'b0;
        step(LAT - 1);
        chk("setup_no_r2", outs, 7'b0010000);
        step(1);
        chk("setup_exit_r2", outs, 7'b0110000);
        KEY_ENTER = 1'b1;
        step(1);
        chk("fpga_state", state, 2);
        chk("fpga_entry_outs", outs, 7'b0100000);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("fpga_e3", outs, (i % 4 == 0) ? 7'b0100100 : 7'b0100000);
            if (i == 8) end_FPGA = 1'b1;   // coincides with a tick
        end
        step(1);
        end_FPGA = 1'b0;
        chk("user_state", state, 3);
        chk("user_entry_outs", outs, 7'b0000000);

        // PLAY_USER: two presses, ticks every 4 cycles
        e2_cnt = 0; e4_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 2)  KEY_ENTER = 1'b0;
            if (i == 10) KEY_ENTER = 1'b1;
            if (i == 14) KEY_ENTER = 1'b0;
            if (i == 22) KEY_ENTER = 1'b1;
            step(1);
            e2_cnt += int'(E2);
            e4_cnt += int'(E4);
        end
        chk("user_e4_two", e4_cnt, 2);
        chk("user_e2_ticks", e2_cnt, 7);
        chk("user_stay", state, 3);

        // CHECK -> NEXT_ROUND -> PLAY_FPGA
        end_User = 1'b1; match = 1'b1; win = 1'b0;
        step(1);
        end_User = 1'b0;
        chk("check_state", state, 4);
        chk("check_outs", outs, 7'b0000000);
        step(1);
        chk("next_state", state, 5);
        chk("next_r2", outs, 7'b0100000);
        step(1);
        chk("next_to_fpga", state, 2);

        // ENTER during PLAY_FPGA is dropped
        KEY_ENTER = 1'b0;
        step(LAT + 2);
        KEY_ENTER = 1'b1;
        step(4);
        end_FPGA = 1'b1;
        step(1);
        end_FPGA = 1'b0;
        chk("discard_state", state, 3);
        e4_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            e4_cnt += int'(E4);
        end
        chk("discard_e4", e4_cnt, 0);

        // Reset mid-game
        RESET = 1'b1;
        step(1);
        chk("midrst_state", state, 0);
        chk("midrst_outs", outs, 7'b1100000);
        RESET = 1'b0;
        step(1);
        chk("midrst_setup", state, 1);
        step(3);

        // Timeout path
        press();
        step(1);
        end_FPGA = 1'b1;
        step(1);
        end_FPGA = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("user_e2", outs, (i == 4) ? 7'b0001000 : 7'b0000000);
        end
        end_time = 1'b1;
        step(1);
        end_time = 1'b0;
        chk("timeout_state", state, 6);
        chk("timeout_outs", outs, 7'b0000001);
        step(3);
        chk("result_hold", state, 6);
        press();
        chk("result_enter_outs", outs, 7'b0000001);
        step(1);
        chk("result_to_init", state, 0);
        chk("init_outs", outs, 7'b1100000);
        step(1);
        chk("init_to_setup", state, 1);

        // end_User and end_time together -> CHECK; mismatch -> RESULT
        step(2);
        press();
        step(1);
        end_FPGA = 1'b1;
        step(1);
        end_FPGA = 1'b0;
        end_User = 1'b1; end_time = 1'b1;
        step(1);
        end_User = 1'b0; end_time = 1'b0;
        chk("simul_check", state, 4);
        match = 1'b0;
        step(1);
        chk("nomatch_result", state, 6);
        press();
        step(2);
        chk("back_setup", state, 1);

        // Key behaviour in PLAY_USER
        step(2);
        press();
        step(1);
        end_FPGA = 1'b1;
        step(1);
        end_FPGA = 1'b0;
        e4_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) KEY_ENTER = 1'b0;
            if (i == 2) KEY_ENTER = 1'b1;
            step(1);
            e4_cnt += int'(E4);
        end
        chk("glitch_e4", e4_cnt, GLITCH_E4);
        e4_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)  KEY_ENTER = 1'b0;
            if (i == 20) KEY_ENTER = 1'b1;
            step(1);
            e4_cnt += int'(E4);
        end
        chk("hold_e4_once", e4_cnt, 1);
        chk("hold_state", state, 3);

        // Win: CHECK with match & win -> RESULT, strobes quiet
        end_User = 1'b1; match = 1'b1; win = 1'b1;
        step(1);
        end_User = 1'b0;
        chk("win_check", state, 4);
        step(1);
        chk("win_result", state, 6);
        for (int i = 0; i < 5; i++) begin
            chk("win_outs", outs, 7'b0000001);
            step(1);
        end
        match = 1'b0; win = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
